// File: rtl/decompress_block_core.sv
// rtl/decompress_block_core.sv - 8x8 block dequantize plus exact integer 2D inverse DCT
module decompress_block_core (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_block,
    input  logic signed [8:0]  quantized_coeffs [8][8],
    output logic signed [62:0] reconstructed_block_out [8][8],
    output logic               block_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEQUANT,
        S_ROW,
        S_COL,
        S_DONE
    } state_t;

    // Luminance quantization table, [vertical freq][horizontal freq]
    localparam logic [7:0] Q_TAB [8][8] = '{
        '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
        '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
        '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
        '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
        '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
        '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
        '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
        '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}
    };

    // IDCT basis C[k][n]: the cosine angle (2n+1)k*pi/16 is folded onto
    // 0..pi/2 so only eight magnitudes (scaled by 2048) are needed.
    function automatic logic signed [12:0] cval(input int k, input int n);
        int                 j;
        logic               neg;
        logic signed [12:0] mag;
        if (k == 0) begin
            return 13'sd1448;
        end
        j = (k * (2 * n + 1)) % 32;
        if (j > 16) begin
            j = 32 - j;
        end
        neg = (j > 8);
        if (neg) begin
            j = 16 - j;
        end
        case (j)
            0:       mag = 13'sd2048;
            1:       mag = 13'sd2009;
            2:       mag = 13'sd1892;
            3:       mag = 13'sd1703;
            4:       mag = 13'sd1448;
            5:       mag = 13'sd1138;
            6:       mag = 13'sd784;
            7:       mag = 13'sd400;
            default: mag = 13'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    state_t             state_q;
    logic [2:0]         idx_q;
    logic               done_q;
    logic signed [8:0]  coef_q [8][8];
    logic signed [16:0] deq_q  [8][8];
    logic signed [32:0] t_q    [8][8];
    logic signed [62:0] out_q  [8][8];

    logic signed [16:0] deq_d [8][8];
    logic signed [32:0] row_d [8];
    logic signed [48:0] col_d [8];

    // Dequantize all 64 coefficients in parallel
    always_comb begin
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                deq_d[u][v] = coef_q[u][v] * $signed({1'b0, Q_TAB[u][v]});
            end
        end
    end

    // Row pass: one full row of T for the row selected by idx_q
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            row_d[n] = '0;
            for (int k = 0; k < 8; k++) begin
                row_d[n] = row_d[n] + deq_q[idx_q][k] * cval(k, n);
            end
        end
    end

    // Column pass: one full output column for the column selected by idx_q
    always_comb begin
        for (int m = 0; m < 8; m++) begin
            col_d[m] = '0;
            for (int k = 0; k < 8; k++) begin
                col_d[m] = col_d[m] + cval(k, m) * t_q[k][idx_q];
            end
        end
    end

    // Sequencer: capture, dequantize, 8 row cycles, 8 column cycles, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    coef_q[a][b] <= '0;
                    deq_q[a][b]  <= '0;
                    t_q[a][b]    <= '0;
                    out_q[a][b]  <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_block) begin
                        coef_q  <= quantized_coeffs;
                        state_q <= S_DEQUANT;
                    end
                end
                S_DEQUANT: begin
                    deq_q   <= deq_d;
                    idx_q   <= '0;
                    state_q <= S_ROW;
                end
                S_ROW: begin
                    for (int n = 0; n < 8; n++) begin
                        t_q[idx_q][n] <= row_d[n];
                    end
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q <= S_COL;
                    end
                end
                S_COL: begin
                    for (int m = 0; m < 8; m++) begin
                        out_q[m][idx_q] <= {{14{col_d[m][48]}}, col_d[m]};
                    end
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign reconstructed_block_out = out_q;
    assign block_done              = done_q;

endmodule

// File: tb/tb_decompress_block_core.sv
// tb/tb_decompress_block_core.sv - self-checking bench for decompress_block_core
module tb_decompress_block_core;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_block;
    logic signed [8:0]  quantized_coeffs [8][8];
    logic signed [62:0] reconstructed_block_out [8][8];
    logic               block_done;

    int checks = 0;
    int errors = 0;

    int q_tab [8][8] = '{
        '{16, 11, 10, 16, 24, 40, 51, 61},
        '{12, 12, 14, 19, 26, 58, 60, 55},
        '{14, 13, 16, 24, 40, 57, 69, 56},
        '{14, 17, 22, 29, 51, 87, 80, 62},
        '{18, 22, 37, 56, 68, 109, 103, 77},
        '{24, 35, 55, 64, 81, 104, 113, 92},
        '{49, 64, 78, 87, 103, 121, 120, 101},
        '{72, 92, 95, 98, 112, 100, 103, 99}
    };
    int     c_tab  [8][8];
    int     coef   [8][8];
    int     coef_b [8][8];
    longint exp_y  [8][8];
    longint exp_b  [8][8];

    always #5 clk = ~clk;

    decompress_block_core dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start_block             (start_block),
        .quantized_coeffs        (quantized_coeffs),
        .reconstructed_block_out (reconstructed_block_out),
        .block_done              (block_done)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Basis from the cosine definition, rounded to nearest
    task automatic build_cos();
        real a, r;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                a = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
                r = 4096.0 * a * $cos((2.0 * n + 1.0) * k * 3.14159265358979323846 / 16.0);
                c_tab[k][n] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
            end
        end
    endtask

    // Direct 2D reconstruction: Y[m][n] = sum_u sum_v C[u][m]*coef*Q*C[v][n]
    task automatic compute_model();
        longint acc;
        for (int m = 0; m < 8; m++) begin
            for (int n = 0; n < 8; n++) begin
                acc = 0;
                for (int u = 0; u < 8; u++) begin
                    for (int v = 0; v < 8; v++) begin
                        acc += longint'(c_tab[u][m]) * coef[u][v] * q_tab[u][v] * c_tab[v][n];
                    end
                end
                exp_y[m][n] = acc;
            end
        end
    endtask

    task automatic drive(input bit use_b);
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                quantized_coeffs[u][v] = use_b ? 9'(coef_b[u][v]) : 9'(coef[u][v]);
            end
        end
    endtask

    task automatic clear_coef();
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                coef[u][v] = 0;
            end
        end
    endtask

    task automatic rand_coef(input bit sparse);
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                if (sparse) begin
                    coef[u][v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) - 40 : 0;
                end else begin
                    coef[u][v] = int'($urandom_range(0, 511)) - 256;
                end
            end
        end
    endtask

    task automatic compare_block(input string tag);
        for (int m = 0; m < 8; m++) begin
            for (int n = 0; n < 8; n++) begin
                check($sformatf("%s y[%0d][%0d]", tag, m, n),
                      longint'(reconstructed_block_out[m][n]), exp_y[m][n]);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int m = 0; m < 8; m++) begin
            for (int n = 0; n < 8; n++) begin
                check($sformatf("%s zero[%0d][%0d]", tag, m, n),
                      longint'(reconstructed_block_out[m][n]), 0);
            end
        end
    endtask

    // Called #1 after a rising edge with the core idle; start held for 'hold' cycles
    task automatic run_block(input string tag, input int hold);
        int lat;
        lat = -1;
        compute_model();
        drive(1'b0);
        start_block = 1'b1;
        @(posedge clk); #1;
        if (hold <= 1) start_block = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == hold - 1) start_block = 1'b0;
            if (block_done) begin
                lat = i;
                break;
            end
        end
        start_block = 1'b0;
        check({tag, " latency"}, lat, 17);
        if (lat > 0) begin
            compare_block(tag);
            @(posedge clk); #1;
            check({tag, " pulse_width"}, longint'(block_done), 0);
        end
    endtask

    initial begin
        int spurious;
        int rising;
        int high_cycles;
        int lat1;
        int lat2;
        bit prev;

        build_cos();
        rst_n       = 1'b0;
        start_block = 1'b0;
        clear_coef();
        drive(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset block_done", longint'(block_done), 0);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        clear_coef();
        run_block("zero", 2);

        clear_coef();
        coef[0][0] = 1;
        run_block("dc_pos", 1);
        check("dc_pos literal", longint'(reconstructed_block_out[3][5]), 64'sd33547264);

        clear_coef();
        coef[0][0] = -1;
        run_block("dc_neg", 1);
        check("dc_neg literal", longint'(reconstructed_block_out[7][0]), -64'sd33547264);

        clear_coef();
        coef[0][1] = 1;
        run_block("ac01", 1);
        check("ac01 literal col0", longint'(reconstructed_block_out[2][0]), 64'sd31999352);
        check("ac01 literal col7", longint'(reconstructed_block_out[4][7]), -64'sd31999352);

        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                coef[u][v] = ((u + v) % 2 == 1) ? 255 : -256;
            end
        end
        run_block("extreme", 1);

        for (int r = 0; r < 6; r++) begin
            rand_coef(r % 2 == 1);
            run_block($sformatf("rand%0d", r), 1 + r % 3);
        end

        // Reset asserted while the row pass is running
        rand_coef(1'b0);
        drive(1'b0);
        start_block = 1'b1;
        @(posedge clk); #1;
        start_block = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset block_done", longint'(block_done), 0);
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (block_done) spurious++;
        end
        check("midreset spurious done", spurious, 0);
        rand_coef(1'b0);
        run_block("after_reset", 1);

        // start_block held high across DONE: two blocks back to back
        rand_coef(1'b0);
        coef_b = coef;
        compute_model();
        exp_b = exp_y;
        rand_coef(1'b1);
        compute_model();
        drive(1'b0);
        start_block = 1'b1;
        rising      = 0;
        high_cycles = 0;
        lat1        = -1;
        lat2        = -1;
        prev        = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) drive(1'b1);
            if (i == 20) start_block = 1'b0;
            if (block_done) begin
                high_cycles++;
                if (!prev) begin
                    rising++;
                    if (rising == 1) begin
                        lat1 = i;
                        compare_block("b2b_first");
                        exp_y = exp_b;
                    end else begin
                        lat2 = i;
                        compare_block("b2b_second");
                    end
                end
            end
            prev = block_done;
        end
        start_block = 1'b0;
        check("b2b first latency", lat1, 17);
        check("b2b second latency", lat2, 36);
        check("b2b pulse count", rising, 2);
        check("b2b high cycles", high_cycles, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
